// File: rtl/uart_rx_ctrl.sv
// UART receiver: oversampled bit sampler, frame FSM, deserializer, parity/stop checks.
// Optional build macro UART_RX_MAJORITY_EN selects 3-sample majority voting at mid-bit.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Par_Err,
  output logic                  Stp_Err
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e                state_q, state_d;
  logic [5:0]            edge_q, edge_d;
  logic [5:0]            presc_q, presc_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic                  parEn_q, parEn_d;
  logic                  parTyp_q, parTyp_d;
  logic                  parFlag_q, parFlag_d;
  logic                  dv_q, dv_d;
  logic                  perr_q, perr_d;
  logic                  serr_q, serr_d;
  logic [5:0]            half;
  logic                  bitEnd;
  logic                  sampleBit;
  logic                  expPar;

  assign half   = {1'b0, presc_q[5:1]};
  assign bitEnd = (edge_q == presc_q - 6'd1);
  assign expPar = parTyp_q ? ~^shift_q : ^shift_q;

`ifdef UART_RX_MAJORITY_EN
  logic [2:0] smp_q, smp_d;

  always_comb begin
    smp_d = smp_q;
    if (state_q != IDLE) begin
      if (edge_q == half - 6'd1) smp_d[0] = RX_IN;
      if (edge_q == half)        smp_d[1] = RX_IN;
      if (edge_q == half + 6'd1) smp_d[2] = RX_IN;
    end
  end

  assign sampleBit = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
`else
  logic smp_q, smp_d;

  always_comb begin
    smp_d = smp_q;
    if ((state_q != IDLE) && (edge_q == half)) smp_d = RX_IN;
  end

  assign sampleBit = smp_q;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      edge_q    <= '0;
      presc_q   <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      pdata_q   <= '0;
      parEn_q   <= 1'b0;
      parTyp_q  <= 1'b0;
      parFlag_q <= 1'b0;
      dv_q      <= 1'b0;
      perr_q    <= 1'b0;
      serr_q    <= 1'b0;
      smp_q     <= '0;
    end else begin
      state_q   <= state_d;
      edge_q    <= edge_d;
      presc_q   <= presc_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      pdata_q   <= pdata_d;
      parEn_q   <= parEn_d;
      parTyp_q  <= parTyp_d;
      parFlag_q <= parFlag_d;
      dv_q      <= dv_d;
      perr_q    <= perr_d;
      serr_q    <= serr_d;
      smp_q     <= smp_d;
    end
  end

  // Parity error is flagged at parity-bit end and pulsed one cycle into the stop bit.
  always_comb begin
    state_d   = state_q;
    edge_d    = edge_q;
    presc_d   = presc_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    pdata_d   = pdata_q;
    parEn_d   = parEn_q;
    parTyp_d  = parTyp_q;
    parFlag_d = parFlag_q;
    dv_d      = 1'b0;
    perr_d    = (state_q == STOP) && (edge_q == 6'd0) && parFlag_q;
    serr_d    = 1'b0;

    if (state_q != IDLE) edge_d = bitEnd ? 6'd0 : edge_q + 6'd1;

    case (state_q)
      IDLE: begin
        presc_d   = Prescale;
        parEn_d   = PAR_EN;
        parTyp_d  = PAR_TYP;
        parFlag_d = 1'b0;
        bit_d     = '0;
        edge_d    = 6'd0;
        if (!RX_IN) begin
          state_d = START;
          edge_d  = 6'd1;
        end
      end
      START: begin
        if (bitEnd) state_d = sampleBit ? IDLE : DATA;
      end
      DATA: begin
        if (bitEnd) begin
          shift_d = {sampleBit, shift_q[DATA_WIDTH-1:1]};
          if (bit_q == BW'(DATA_WIDTH - 1)) begin
            bit_d   = '0;
            state_d = parEn_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      PARITY: begin
        if (bitEnd) begin
          parFlag_d = (sampleBit != expPar);
          state_d   = STOP;
        end
      end
      STOP: begin
        if (bitEnd) begin
          state_d = IDLE;
          serr_d  = ~sampleBit;
          if (sampleBit && !parFlag_q) begin
            pdata_d = shift_q;
            dv_d    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign P_DATA     = pdata_q;
  assign Data_Valid = dv_q;
  assign Par_Err    = perr_q;
  assign Stp_Err    = serr_q;

endmodule
